// File: rtl/fft_input_reorder_if.sv
// Stream bundle for the FFT input reorder stage: natural-order samples in,
// bit-reversed four-lane butterfly beats out.
interface fft_input_reorder_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_r;
  logic [DATA_W-1:0] in_i;
  logic              out_valid;
  logic              out_ready;
  logic              out_first;
  logic              out_last;
  logic [DATA_W-1:0] out0_r;
  logic [DATA_W-1:0] out0_i;
  logic [DATA_W-1:0] out1_r;
  logic [DATA_W-1:0] out1_i;
  logic [DATA_W-1:0] out2_r;
  logic [DATA_W-1:0] out2_i;
  logic [DATA_W-1:0] out3_r;
  logic [DATA_W-1:0] out3_i;

  modport slave (
    input  in_valid, in_r, in_i, out_ready,
    output in_ready, out_valid, out_first, out_last,
    output out0_r, out0_i, out1_r, out1_i, out2_r, out2_i, out3_r, out3_i
  );

  modport master (
    output in_valid, in_r, in_i, out_ready,
    input  in_ready, out_valid, out_first, out_last,
    input  out0_r, out0_i, out1_r, out1_i, out2_r, out2_i, out3_r, out3_i
  );
endinterface

// File: rtl/fft_input_reorder.sv
// 32-point FFT input stage: ping-pong frame banks, read out as 8 bit-reversed beats.
// Define FFT_IN_SCALE_EN to store every component prescaled by >>> LOG2N.
module fft_input_reorder #(
  parameter int DATA_W = 32,
  parameter int N      = 32,
  parameter int LOG2N  = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  fft_input_reorder_if.slave   io_bus
);
  typedef enum logic {S_IDLE, S_STREAM} state_t;

  logic [2*DATA_W-1:0] r_mem [2][N];
  logic [1:0]          r_full;
  logic                r_wr_bank;
  logic [LOG2N-1:0]    r_wr_cnt;
  logic                r_rd_bank;
  logic [2:0]          r_rd_beat;
  state_t              r_state;
  logic                r_out_valid;
  logic                r_out_first;
  logic                r_out_last;
  logic [DATA_W-1:0]   r_out_r [4];
  logic [DATA_W-1:0]   r_out_i [4];

  logic                w_in_ready;
  logic                w_wr_en;
  logic                w_fill;
  logic [DATA_W-1:0]   w_in_r;
  logic [DATA_W-1:0]   w_in_i;
  logic                w_ld_en;
  logic                w_ld_bank;
  logic [2:0]          w_ld_beat;
  logic [2:0]          w_ld_m;
  logic                w_rel;
  logic [2*DATA_W-1:0] w_ld_word [4];

  assign w_in_ready = !r_full[r_wr_bank];
  assign w_wr_en    = io_bus.in_valid && w_in_ready;
  assign w_fill     = w_wr_en && (r_wr_cnt == LOG2N'(N - 1));

`ifdef FFT_IN_SCALE_EN
  assign w_in_r = DATA_W'($signed(io_bus.in_r) >>> LOG2N);
  assign w_in_i = DATA_W'($signed(io_bus.in_i) >>> LOG2N);
`else
  assign w_in_r = io_bus.in_r;
  assign w_in_i = io_bus.in_i;
`endif

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_bank][r_wr_cnt] <= {w_in_r, w_in_i};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_cnt  <= '0;
      r_wr_bank <= 1'b0;
    end else if (w_wr_en) begin
      r_wr_cnt <= r_wr_cnt + 1'b1;
      if (w_fill) r_wr_bank <= ~r_wr_bank;
    end
  end

  // Write only fills a non-full bank and read only releases a full one, so no conflict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full <= 2'b00;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (w_fill && (r_wr_bank == 1'(b)))      r_full[b] <= 1'b1;
        else if (w_rel && (r_rd_bank == 1'(b)))  r_full[b] <= 1'b0;
      end
    end
  end

  always_comb begin
    w_ld_en   = 1'b0;
    w_ld_bank = r_rd_bank;
    w_ld_beat = 3'd0;
    w_rel     = 1'b0;
    case (r_state)
      S_IDLE: w_ld_en = r_full[r_rd_bank];
      S_STREAM: begin
        if (io_bus.out_ready) begin
          if (r_rd_beat != 3'd7) begin
            w_ld_en   = 1'b1;
            w_ld_beat = r_rd_beat + 3'd1;
          end else begin
            w_rel     = 1'b1;
            w_ld_bank = ~r_rd_bank;
            w_ld_en   = r_full[~r_rd_bank];
          end
        end
      end
      default: ;
    endcase
  end

  // Beat k reads x[m + 8*lane] with m = bitrev3(k).
  assign w_ld_m = {w_ld_beat[0], w_ld_beat[1], w_ld_beat[2]};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign w_ld_word[gi] = r_mem[w_ld_bank][{2'(gi), w_ld_m}];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rd_bank   <= 1'b0;
      r_rd_beat   <= 3'd0;
      r_out_valid <= 1'b0;
      r_out_first <= 1'b0;
      r_out_last  <= 1'b0;
      for (int j = 0; j < 4; j++) begin
        r_out_r[j] <= '0;
        r_out_i[j] <= '0;
      end
    end else if (w_ld_en) begin
      r_state     <= S_STREAM;
      r_rd_bank   <= w_ld_bank;
      r_rd_beat   <= w_ld_beat;
      r_out_valid <= 1'b1;
      r_out_first <= (w_ld_beat == 3'd0);
      r_out_last  <= (w_ld_beat == 3'd7);
      for (int j = 0; j < 4; j++) begin
        r_out_r[j] <= w_ld_word[j][2*DATA_W-1:DATA_W];
        r_out_i[j] <= w_ld_word[j][DATA_W-1:0];
      end
    end else if (w_rel) begin
      r_state     <= S_IDLE;
      r_rd_bank   <= ~r_rd_bank;
      r_rd_beat   <= 3'd0;
      r_out_valid <= 1'b0;
      r_out_first <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

  assign io_bus.in_ready  = w_in_ready;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.out_first = r_out_first;
  assign io_bus.out_last  = r_out_last;
  assign io_bus.out0_r    = r_out_r[0];
  assign io_bus.out0_i    = r_out_i[0];
  assign io_bus.out1_r    = r_out_r[1];
  assign io_bus.out1_i    = r_out_i[1];
  assign io_bus.out2_r    = r_out_r[2];
  assign io_bus.out2_i    = r_out_i[2];
  assign io_bus.out3_r    = r_out_r[3];
  assign io_bus.out3_i    = r_out_i[3];
endmodule

// File: tb/tb_fft_input_reorder.sv
// Scoreboard bench for fft_input_reorder: frames modelled on acceptance,
// beats checked in order on each output handshake.
module tb_fft_input_reorder;
  localparam int DW = 32;
`ifdef FFT_IN_SCALE_EN
  localparam logic [31:0] EXP_MIN = 32'hFC000000;
`else
  localparam logic [31:0] EXP_MIN = 32'h80000000;
`endif

  typedef struct packed {
    logic [3:0][31:0] r;
    logic [3:0][31:0] i;
    logic             first;
    logic             last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft_input_reorder_if #(.DATA_W(DW)) bif ();
  fft_input_reorder #(.DATA_W(DW), .N(32), .LOG2N(5)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bif)
  );

  beat_t       sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] m_r [32];
  logic [31:0] m_i [32];
  int          m_cnt = 0;
  int          n_beats = 0;
  int          n_in_block = 0;
  int          n_gap = 0;
  logic        watch_gap = 1'b0;
  logic        const_chk = 1'b0;
  logic        stalled = 1'b0;
  beat_t       held, cur, cap0, cap7;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic compare_beat(input string tag, input beat_t got, input beat_t exp);
    for (int j = 0; j < 4; j++) begin
      check_val($sformatf("%s_out%0d_r", tag, j), 64'(got.r[j]), 64'(exp.r[j]));
      check_val($sformatf("%s_out%0d_i", tag, j), 64'(got.i[j]), 64'(exp.i[j]));
    end
    check_val({tag, "_first"}, 64'(got.first), 64'(exp.first));
    check_val({tag, "_last"},  64'(got.last),  64'(exp.last));
  endtask

  function automatic logic [31:0] scale(input logic [31:0] x);
`ifdef FFT_IN_SCALE_EN
    return 32'($signed(x) >>> 5);
`else
    return x;
`endif
  endfunction

  function automatic beat_t cur_beat();
    beat_t b;
    b.r[0] = bif.out0_r; b.i[0] = bif.out0_i;
    b.r[1] = bif.out1_r; b.i[1] = bif.out1_i;
    b.r[2] = bif.out2_r; b.i[2] = bif.out2_i;
    b.r[3] = bif.out3_r; b.i[3] = bif.out3_i;
    b.first = bif.out_first;
    b.last  = bif.out_last;
    return b;
  endfunction

  task automatic push_frame();
    beat_t       e;
    logic [2:0]  kb;
    int          m;
    for (int k = 0; k < 8; k++) begin
      kb = 3'(k);
      m  = int'({kb[0], kb[1], kb[2]});
      for (int j = 0; j < 4; j++) begin
        e.r[j] = scale(m_r[j * 8 + m]);
        e.i[j] = scale(m_i[j * 8 + m]);
      end
      e.first = (k == 0);
      e.last  = (k == 7);
      sb_q.push_back(e);
    end
  endtask

  // Everything observed at negedge refers to what the next rising edge will do.
  always @(negedge clk) begin
    if (rst) begin
      m_cnt   = 0;
      sb_q.delete();
      stalled = 1'b0;
    end else begin
      cur = cur_beat();
      if (bif.in_valid && bif.in_ready) begin
        m_r[m_cnt] = bif.in_r;
        m_i[m_cnt] = bif.in_i;
        m_cnt++;
        if (m_cnt == 32) begin
          push_frame();
          m_cnt = 0;
        end
      end
      if (bif.in_valid && !bif.in_ready) n_in_block++;
      if (stalled) begin
        check_val("stall_valid", 64'(bif.out_valid), 64'd1);
        compare_beat("stall_hold", cur, held);
      end
      if (bif.out_valid && bif.out_ready) begin
        if (sb_q.size() == 0) begin
          check_val("unexpected_beat", 64'd1, 64'd0);
        end else begin
          compare_beat("beat", cur, sb_q.pop_front());
        end
        if (const_chk) begin
          for (int j = 0; j < 4; j++)
            check_val($sformatf("min_out%0d_r", j), 64'(cur.r[j]), 64'(EXP_MIN));
        end
        if (cur.first) cap0 = cur;
        if (cur.last)  cap7 = cur;
        n_beats++;
      end
      if (watch_gap && !bif.out_valid && sb_q.size() != 0) n_gap++;
      stalled = bif.out_valid && !bif.out_ready;
      held    = cur;
    end
  end

  task automatic send(input logic [31:0] r, input logic [31:0] i);
    int t = 0;
    bif.in_valid = 1'b1;
    bif.in_r     = r;
    bif.in_i     = i;
    @(negedge clk);
    while (!bif.in_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (!bif.in_ready) check_val("send_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    bif.in_valid = 1'b0;
  endtask

  task automatic send_ramp(input int base);
    for (int n = 0; n < 32; n++) send(32'(base + n), 32'(-(base + n)));
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while (sb_q.size() != 0 && t < 1000) begin
      @(posedge clk);
      t++;
    end
    check_val({tag, "_drained"}, 64'(sb_q.size()), 64'd0);
    @(posedge clk);
    #1;
    check_val({tag, "_idle_valid"}, 64'(bif.out_valid), 64'd0);
  endtask

  task automatic check_ramp_caps(input string tag);
    for (int j = 0; j < 4; j++) begin
      check_val($sformatf("%s_b0_out%0d_r", tag, j), 64'(cap0.r[j]), 64'(scale(32'(j * 8))));
      check_val($sformatf("%s_b0_out%0d_i", tag, j), 64'(cap0.i[j]), 64'(scale(32'(-(j * 8)))));
      check_val($sformatf("%s_b7_out%0d_r", tag, j), 64'(cap7.r[j]), 64'(scale(32'(7 + j * 8))));
      check_val($sformatf("%s_b7_out%0d_i", tag, j), 64'(cap7.i[j]), 64'(scale(32'(-(7 + j * 8)))));
    end
  endtask

  initial begin
    int t;
    int beats_before;
    bif.in_valid  = 1'b0;
    bif.in_r      = '0;
    bif.in_i      = '0;
    bif.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_out_valid", 64'(bif.out_valid), 64'd0);
    check_val("rst_out_first", 64'(bif.out_first), 64'd0);
    check_val("rst_out_last",  64'(bif.out_last),  64'd0);
    check_val("rst_out0_r",    64'(bif.out0_r),    64'd0);
    check_val("rst_out3_i",    64'(bif.out3_i),    64'd0);
    check_val("rst_in_ready",  64'(bif.in_ready),  64'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Ramp frame, plus one-bubble latency from the last accepted sample.
    bif.out_ready = 1'b1;
    send_ramp(0);
    check_val("lat_bubble_valid", 64'(bif.out_valid), 64'd0);
    @(posedge clk);
    #1;
    check_val("lat_beat0_valid", 64'(bif.out_valid), 64'd1);
    check_val("lat_beat0_first", 64'(bif.out_first), 64'd1);
    drain("s1");
    check_ramp_caps("s1");
    $display("scenario ramp done: beats=%0d", n_beats);

    // Three frames back to back must never block the writer.
    n_in_block = 0;
    for (int f = 0; f < 3; f++) send_ramp(100 * (f + 1));
    check_val("b2b_in_blocked", 64'(n_in_block), 64'd0);
    drain("b2b");
    $display("scenario back-to-back done: beats=%0d", n_beats);

    // Stall output while two frames fill both banks.
    bif.out_ready = 1'b0;
    send_ramp(1000);
    send_ramp(2000);
    check_val("full_in_ready", 64'(bif.in_ready), 64'd0);
    bif.in_valid = 1'b1;
    bif.in_r     = 32'hDEAD_BEEF;
    bif.in_i     = 32'h1234_5678;
    repeat (4) @(negedge clk);
    check_val("full_in_ready_held", 64'(bif.in_ready), 64'd0);
    check_val("full_out_valid", 64'(bif.out_valid), 64'd1);
    @(posedge clk);
    #1;
    bif.in_valid  = 1'b0;
    watch_gap     = 1'b1;
    beats_before  = n_beats;
    bif.out_ready = 1'b1;
    t = 0;
    while (t < 40) begin
      @(posedge clk);
      #2;
      if (bif.in_ready) break;
      t++;
    end
    check_val("release_beats", 64'(n_beats - beats_before), 64'd8);
    drain("stall");
    check_val("stall_gap", 64'(n_gap), 64'd0);
    watch_gap = 1'b0;
    $display("scenario stall done: beats=%0d", n_beats);

    // Random backpressure during a random-data frame.
    fork
      begin
        repeat (200) begin
          @(posedge clk);
          #1;
          bif.out_ready = 1'($urandom_range(0, 1));
        end
        bif.out_ready = 1'b1;
      end
      begin
        for (int n = 0; n < 32; n++) send($urandom, $urandom);
      end
    join
    drain("rand");
    $display("scenario random backpressure done: beats=%0d", n_beats);

    // Abort a partial frame with reset, then a clean ramp.
    for (int n = 0; n < 17; n++) send(32'(5000 + n), 32'(7000 + n));
    rst = 1'b1;
    #1;
    check_val("abort_in_ready", 64'(bif.in_ready), 64'd1);
    check_val("abort_out_valid", 64'(bif.out_valid), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    send_ramp(0);
    drain("abort");
    check_ramp_caps("abort");
    $display("scenario reset abort done: beats=%0d", n_beats);

    // Most negative real component.
    const_chk = 1'b1;
    for (int n = 0; n < 32; n++) send(32'h8000_0000, 32'(n));
    drain("min");
    const_chk = 1'b0;
    $display("scenario min value done: beats=%0d", n_beats);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
